// File: rtl/divider_rr_arbiter_if.sv
// Requester/response bundle for the shared divider: NUM_REQ operand ports in,
// one tagged result stream out.
interface divider_rr_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_ready;
  logic [NUM_REQ*8-1:0] req_lop;
  logic [NUM_REQ*8-1:0] req_rop;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [ID_W-1:0]      rsp_id;
  logic [7:0]           rsp_quot;
  logic [7:0]           rsp_mod;
  logic                 rsp_dz;

  modport master (
    output req_valid, req_lop, req_rop, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_quot, rsp_mod, rsp_dz
  );

  modport slave (
    input  req_valid, req_lop, req_rop, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_quot, rsp_mod, rsp_dz
  );
endinterface

// File: rtl/divider_rr_arbiter.sv
// Round-robin front end sharing one unsigned 8-bit restoring divider between
// NUM_REQ requesters through a two-stage operand/result pipeline.
module divider_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  divider_rr_arbiter_if.slave  bus,
  output logic                 busy
);
  localparam int DATA_W = 8;

  // Divide-by-zero falls out naturally: every trial subtract succeeds, so
  // quotient saturates to all ones and the remainder is the dividend.
  function automatic logic [2*DATA_W-1:0] restoring_div(
    input logic [DATA_W-1:0] lop,
    input logic [DATA_W-1:0] rop
  );
    logic [DATA_W:0]   rem;
    logic [DATA_W-1:0] quot;
    rem  = '0;
    quot = '0;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      rem = {rem[DATA_W-1:0], lop[i]};
      if (rem >= {1'b0, rop}) begin
        rem     = rem - {1'b0, rop};
        quot[i] = 1'b1;
      end
    end
    return {quot, rem[DATA_W-1:0]};
  endfunction

  logic [NUM_REQ-1:0]  grant;
  logic [ID_W-1:0]     grant_id;
  logic [ID_W-1:0]     rr_ptr;
  logic                hs;
  logic                s1_free;
  logic                s2_load;
  logic                vld_p1, vld_p1_nxt;
  logic                vld_p2, vld_p2_nxt;
  logic [DATA_W-1:0]   lop_p1, rop_p1;
  logic [ID_W-1:0]     id_p1;
  logic [DATA_W-1:0]   quot_p2, mod_p2;
  logic                dz_p2;
  logic [ID_W-1:0]     id_p2;
  logic [2*DATA_W-1:0] div_res;

  always_comb begin
    int idx;
    grant    = '0;
    grant_id = '0;
    idx      = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (grant == '0 && bus.req_valid[idx]) begin
        grant[idx] = 1'b1;
        grant_id   = ID_W'(idx);
      end
    end
  end

  assign s2_load       = vld_p1 & (~vld_p2 | bus.rsp_ready);
  assign s1_free       = ~vld_p1 | s2_load;
  assign bus.req_ready = grant & {NUM_REQ{s1_free}};
  assign hs            = |bus.req_ready;

  always_comb begin
    vld_p1_nxt = vld_p1;
    vld_p2_nxt = vld_p2;
    if (hs)           vld_p1_nxt = 1'b1;
    else if (s2_load) vld_p1_nxt = 1'b0;
    if (s2_load)            vld_p2_nxt = 1'b1;
    else if (bus.rsp_ready) vld_p2_nxt = 1'b0;
  end

  // Stage 1: operand capture from the granted requester
  always_ff @(posedge clk) begin
    if (hs) begin
      lop_p1 <= bus.req_lop[int'(grant_id)*DATA_W +: DATA_W];
      rop_p1 <= bus.req_rop[int'(grant_id)*DATA_W +: DATA_W];
      id_p1  <= grant_id;
    end
  end

  assign div_res = restoring_div(lop_p1, rop_p1);

  // Stage 2: result register driving the response port
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1  <= 1'b0;
      vld_p2  <= 1'b0;
      busy    <= 1'b0;
      rr_ptr  <= ID_W'(NUM_REQ - 1);
      quot_p2 <= '0;
      mod_p2  <= '0;
      dz_p2   <= 1'b0;
      id_p2   <= '0;
    end else begin
      vld_p1 <= vld_p1_nxt;
      vld_p2 <= vld_p2_nxt;
      busy   <= vld_p1_nxt | vld_p2_nxt;
      if (hs) rr_ptr <= grant_id;
      if (s2_load) begin
        quot_p2 <= div_res[2*DATA_W-1:DATA_W];
        mod_p2  <= div_res[DATA_W-1:0];
        dz_p2   <= (rop_p1 == '0);
        id_p2   <= id_p1;
      end
    end
  end

  assign bus.rsp_valid = vld_p2;
  assign bus.rsp_id    = id_p2;
  assign bus.rsp_quot  = quot_p2;
  assign bus.rsp_mod   = mod_p2;
  assign bus.rsp_dz    = dz_p2;
endmodule

// File: tb/tb_divider_rr_arbiter.sv
// Bench for divider_rr_arbiter: directed scenarios plus a randomized run
// against a queue-based reference of arbitration order and / % results.
module tb_divider_rr_arbiter;
  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [NUM_REQ-1:0]   req_valid = '0;
  logic [NUM_REQ*8-1:0] req_lop = '0;
  logic [NUM_REQ*8-1:0] req_rop = '0;
  logic                 rsp_ready = 1'b1;
  logic                 busy;

  divider_rr_arbiter_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();
  assign bus.req_valid = req_valid;
  assign bus.req_lop   = req_lop;
  assign bus.req_rop   = req_rop;
  assign bus.rsp_ready = rsp_ready;

  divider_rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .clk(clk), .reset(reset), .bus(bus), .busy(busy)
  );

  int n_checks = 0;
  int n_fail = 0;
  bit auto_drop = 1'b1;
  logic [NUM_REQ-1:0] hs_latched = '0;
  int g_id_q[$];
  int r_id_q[$], r_quot_q[$], r_mod_q[$], r_dz_q[$];

  // Log grants and delivered responses for the directed scenarios
  always @(negedge clk) begin
    hs_latched = reset ? '0 : (req_valid & bus.req_ready);
    if (!reset) begin
      for (int i = 0; i < NUM_REQ; i++) if (hs_latched[i]) g_id_q.push_back(i);
      if (bus.rsp_valid && rsp_ready) begin
        r_id_q.push_back(int'(bus.rsp_id));
        r_quot_q.push_back(int'(bus.rsp_quot));
        r_mod_q.push_back(int'(bus.rsp_mod));
        r_dz_q.push_back(int'(bus.rsp_dz));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (auto_drop) req_valid = req_valid & ~hs_latched;
  endtask

  task automatic set_op(input int i, input int lop, input int rop);
    req_lop[8*i +: 8] = 8'(lop);
    req_rop[8*i +: 8] = 8'(rop);
  endtask

  task automatic clear_logs();
    g_id_q.delete(); r_id_q.delete(); r_quot_q.delete(); r_mod_q.delete(); r_dz_q.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1; req_valid = '0; rsp_ready = 1'b1; auto_drop = 1'b1;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic wait_rsp(input int n, input int bound, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < bound; c++) begin
      if (r_id_q.size() >= n) begin ok = 1'b1; break; end
      tick();
    end
    if (r_id_q.size() >= n) ok = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = '0; rsp_ready = 1'b1; auto_drop = 1'b1;
    tick(); tick();
    req_valid = 4'b0110;
    @(negedge clk);
    n_checks++; if (bus.req_ready !== 4'b0010) begin n_fail++; $display("FAIL reset_prio: got %b expected 0010", bus.req_ready); end
    n_checks++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b expected 0", bus.rsp_valid); end
    n_checks++; if ({bus.rsp_quot, bus.rsp_mod} !== 16'h0) begin n_fail++; $display("FAIL reset_data: got %h expected 0000", {bus.rsp_quot, bus.rsp_mod}); end
    n_checks++; if ({bus.rsp_dz, bus.rsp_id} !== 3'b0) begin n_fail++; $display("FAIL reset_dz_id: got %b expected 000", {bus.rsp_dz, bus.rsp_id}); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    tick();
    req_valid = '0; reset = 1'b0;
    tick();
    @(negedge clk);
    n_checks++; if ({bus.rsp_valid, busy} !== 2'b00) begin n_fail++; $display("FAIL reset_no_capture: got %b expected 00", {bus.rsp_valid, busy}); end
  endtask

  task automatic test_single();
    do_reset(); clear_logs();
    set_op(0, 200, 7); req_valid = 4'b0001;
    @(negedge clk);
    n_checks++; if (bus.req_ready !== 4'b0001) begin n_fail++; $display("FAIL single_ready: got %b expected 0001", bus.req_ready); end
    tick();
    @(negedge clk);
    n_checks++; if ({bus.rsp_valid, busy} !== 2'b01) begin n_fail++; $display("FAIL single_s1: got %b expected 01", {bus.rsp_valid, busy}); end
    tick();
    @(negedge clk);
    n_checks++; if (bus.rsp_valid !== 1'b1) begin n_fail++; $display("FAIL single_latency: got %b expected 1", bus.rsp_valid); end
    n_checks++; if (bus.rsp_quot !== 8'd28) begin n_fail++; $display("FAIL single_quot: got %0d expected 28", bus.rsp_quot); end
    n_checks++; if (bus.rsp_mod !== 8'd4) begin n_fail++; $display("FAIL single_mod: got %0d expected 4", bus.rsp_mod); end
    n_checks++; if ({bus.rsp_dz, bus.rsp_id} !== 3'b000) begin n_fail++; $display("FAIL single_dz_id: got %b expected 000", {bus.rsp_dz, bus.rsp_id}); end
    tick();
    @(negedge clk);
    n_checks++; if ({bus.rsp_valid, busy} !== 2'b00) begin n_fail++; $display("FAIL single_idle: got %b expected 00", {bus.rsp_valid, busy}); end
  endtask

  task automatic test_multi();
    int e_id[3]   = '{1, 2, 3};
    int e_quot[3] = '{255, 0, 255};
    int e_mod[3]  = '{0, 5, 13};
    int e_dz[3]   = '{0, 0, 1};
    bit ok;
    do_reset(); clear_logs();
    set_op(1, 255, 1); set_op(2, 5, 9); set_op(3, 13, 0);
    req_valid = 4'b1110;
    wait_rsp(3, 20, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL multi_count: got %0d responses expected 3", r_id_q.size()); end
    for (int k = 0; k < 3; k++) begin
      if (k < r_id_q.size()) begin
        n_checks++;
        if (r_id_q[k] != e_id[k] || r_quot_q[k] != e_quot[k] || r_mod_q[k] != e_mod[k] || r_dz_q[k] != e_dz[k]) begin
          n_fail++;
          $display("FAIL multi_rsp%0d: got id=%0d q=%0d m=%0d dz=%0d expected id=%0d q=%0d m=%0d dz=%0d",
                   k, r_id_q[k], r_quot_q[k], r_mod_q[k], r_dz_q[k], e_id[k], e_quot[k], e_mod[k], e_dz[k]);
        end
      end
    end
  endtask

  task automatic test_round_robin();
    int eid;
    do_reset(); clear_logs();
    auto_drop = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) set_op(i, 40 + i*50, i + 2);
    req_valid = '1;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (c == 8) req_valid = '0;
      @(negedge clk);
      n_checks++;
      if (bus.rsp_valid !== ((c >= 2 && c <= 9) ? 1'b1 : 1'b0)) begin
        n_fail++; $display("FAIL rr_valid_c%0d: got %b", c, bus.rsp_valid);
      end else if (c >= 2 && c <= 9) begin
        eid = (c - 2) % NUM_REQ;
        n_checks++;
        if ({bus.rsp_id, bus.rsp_quot, bus.rsp_mod} !== {ID_W'(eid), 8'((40 + eid*50) / (eid + 2)), 8'((40 + eid*50) % (eid + 2))}) begin
          n_fail++; $display("FAIL rr_rsp_c%0d: got id=%0d q=%0d m=%0d expected id=%0d", c, bus.rsp_id, bus.rsp_quot, bus.rsp_mod, eid);
        end
      end
    end
    auto_drop = 1'b1;
    n_checks++; if (g_id_q.size() != 8) begin n_fail++; $display("FAIL rr_grant_count: got %0d expected 8", g_id_q.size()); end
    for (int k = 0; k < g_id_q.size() && k < 8; k++) begin
      n_checks++; if (g_id_q[k] != k % NUM_REQ) begin n_fail++; $display("FAIL rr_grant%0d: got %0d expected %0d", k, g_id_q[k], k % NUM_REQ); end
    end
  endtask

  task automatic test_stall();
    int e_id[3]   = '{2, 3, 0};
    int e_quot[3] = '{33, 7, 4};
    int e_mod[3]  = '{1, 7, 1};
    bit ok;
    do_reset(); clear_logs();
    rsp_ready = 1'b0;
    set_op(2, 100, 3); set_op(3, 77, 10);
    req_valid = 4'b1100;
    for (int c = 0; c < 10; c++) begin
      if (g_id_q.size() >= 2) break;
      tick();
    end
    n_checks++; if (g_id_q.size() != 2) begin n_fail++; $display("FAIL stall_fill: got %0d grants expected 2", g_id_q.size()); end
    set_op(0, 9, 2); req_valid = req_valid | 4'b0001;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_checks++; if (bus.req_ready !== 4'b0000) begin n_fail++; $display("FAIL stall_ready_c%0d: got %b expected 0000", c, bus.req_ready); end
      n_checks++;
      if ({bus.rsp_valid, bus.rsp_id, bus.rsp_quot, bus.rsp_mod, bus.rsp_dz} !== {1'b1, 2'd2, 8'd33, 8'd1, 1'b0}) begin
        n_fail++; $display("FAIL stall_hold_c%0d: got v=%b id=%0d q=%0d m=%0d expected v=1 id=2 q=33 m=1",
                           c, bus.rsp_valid, bus.rsp_id, bus.rsp_quot, bus.rsp_mod);
      end
      tick();
    end
    rsp_ready = 1'b1;
    wait_rsp(3, 20, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL stall_count: got %0d responses expected 3", r_id_q.size()); end
    for (int k = 0; k < 3 && k < r_id_q.size(); k++) begin
      n_checks++;
      if (r_id_q[k] != e_id[k] || r_quot_q[k] != e_quot[k] || r_mod_q[k] != e_mod[k]) begin
        n_fail++; $display("FAIL stall_rsp%0d: got id=%0d q=%0d m=%0d expected id=%0d q=%0d m=%0d",
                           k, r_id_q[k], r_quot_q[k], r_mod_q[k], e_id[k], e_quot[k], e_mod[k]);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    do_reset(); clear_logs();
    rsp_ready = 1'b0;
    set_op(0, 50, 5); set_op(1, 60, 6);
    req_valid = 4'b0011;
    for (int c = 0; c < 10; c++) begin
      if (g_id_q.size() >= 2) break;
      tick();
    end
    req_valid = '0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    n_checks++; if ({bus.rsp_valid, busy} !== 2'b00) begin n_fail++; $display("FAIL mid_reset_flush: got %b expected 00", {bus.rsp_valid, busy}); end
    rsp_ready = 1'b1;
    repeat (5) tick();
    n_checks++; if (r_id_q.size() != 0) begin n_fail++; $display("FAIL mid_reset_ghost: got %0d responses expected 0", r_id_q.size()); end
    for (int i = 0; i < NUM_REQ; i++) set_op(i, 99, 4 + i);
    req_valid = '1;
    @(negedge clk);
    n_checks++; if (bus.req_ready !== 4'b0001) begin n_fail++; $display("FAIL mid_reset_prio: got %b expected 0001", bus.req_ready); end
    tick();
    req_valid = '0;
    wait_rsp(1, 10, ok);
    n_checks++;
    if (!ok || r_id_q[0] != 0 || r_quot_q[0] != 24 || r_mod_q[0] != 3) begin
      n_fail++; $display("FAIL mid_reset_next: got %0d responses expected one id=0 q=24 m=3", r_id_q.size());
    end
  endtask

  task automatic test_random();
    int exp_id_q[$], exp_q_q[$], exp_m_q[$], exp_dz_q[$];
    int waiting[NUM_REQ];
    int mptr, ops, cycles, e, j, sel, lop, rop;
    logic [NUM_REQ-1:0] exp_rdy;
    bit can_acc;
    do_reset(); clear_logs();
    mptr = NUM_REQ - 1; ops = 0; cycles = 0;
    for (int i = 0; i < NUM_REQ; i++) waiting[i] = 0;
    while (ops < 10000 && cycles < 60000) begin
      tick(); cycles++;
      rsp_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!req_valid[i] && $urandom_range(0, 3) != 0) begin
          sel = $urandom_range(0, 7);
          lop = $urandom_range(0, 255);
          rop = (sel == 0) ? 0 : (sel < 3) ? $urandom_range(1, 15) : $urandom_range(0, 255);
          set_op(i, lop, rop);
          req_valid[i] = 1'b1;
          waiting[i] = 0;
        end
      end
      @(negedge clk);
      can_acc = (exp_id_q.size() < 2) || rsp_ready;
      e = -1;
      if (can_acc) for (int k = 1; k <= NUM_REQ; k++) begin
        j = (mptr + k) % NUM_REQ;
        if (e < 0 && req_valid[j]) e = j;
      end
      exp_rdy = (e >= 0) ? NUM_REQ'(1 << e) : '0;
      n_checks++; if (bus.req_ready !== exp_rdy) begin n_fail++; $display("FAIL rand_grant cyc%0d: got %b expected %b", cycles, bus.req_ready, exp_rdy); end
      if (bus.rsp_valid === 1'b1) begin
        n_checks++;
        if (exp_id_q.size() == 0) begin
          n_fail++; $display("FAIL rand_spurious cyc%0d: got rsp_valid=1 expected nothing in flight", cycles);
        end else begin
          if ({bus.rsp_id, bus.rsp_quot, bus.rsp_mod, bus.rsp_dz} !== {ID_W'(exp_id_q[0]), 8'(exp_q_q[0]), 8'(exp_m_q[0]), exp_dz_q[0] != 0}) begin
            n_fail++; $display("FAIL rand_rsp cyc%0d: got id=%0d q=%0d m=%0d dz=%b expected id=%0d q=%0d m=%0d dz=%0d", cycles,
                               bus.rsp_id, bus.rsp_quot, bus.rsp_mod, bus.rsp_dz, exp_id_q[0], exp_q_q[0], exp_m_q[0], exp_dz_q[0]);
          end
          if (rsp_ready) begin
            void'(exp_id_q.pop_front()); void'(exp_q_q.pop_front());
            void'(exp_m_q.pop_front());  void'(exp_dz_q.pop_front());
          end
        end
      end
      if (e >= 0) begin
        lop = int'(req_lop[8*e +: 8]);
        rop = int'(req_rop[8*e +: 8]);
        exp_id_q.push_back(e);
        exp_q_q.push_back(rop == 0 ? 255 : lop / rop);
        exp_m_q.push_back(rop == 0 ? lop : lop % rop);
        exp_dz_q.push_back(rop == 0 ? 1 : 0);
        for (int i = 0; i < NUM_REQ; i++) begin
          if (i != e && req_valid[i]) begin
            waiting[i]++;
            n_checks++; if (waiting[i] > NUM_REQ - 1) begin n_fail++; $display("FAIL rand_starve req%0d: got %0d grants waited expected <= %0d", i, waiting[i], NUM_REQ - 1); end
          end
        end
        waiting[e] = 0;
        mptr = e;
        ops++;
      end
    end
    n_checks++; if (ops != 10000) begin n_fail++; $display("FAIL rand_progress: got %0d ops expected 10000", ops); end
    tick();
    req_valid = '0; rsp_ready = 1'b1;
    for (int c = 0; c < 10 && exp_id_q.size() > 0; c++) begin
      @(negedge clk);
      if (bus.rsp_valid === 1'b1) begin
        n_checks++;
        if ({bus.rsp_id, bus.rsp_quot, bus.rsp_mod, bus.rsp_dz} !== {ID_W'(exp_id_q[0]), 8'(exp_q_q[0]), 8'(exp_m_q[0]), exp_dz_q[0] != 0}) begin
          n_fail++; $display("FAIL rand_drain: got id=%0d q=%0d m=%0d expected id=%0d q=%0d m=%0d",
                             bus.rsp_id, bus.rsp_quot, bus.rsp_mod, exp_id_q[0], exp_q_q[0], exp_m_q[0]);
        end
        void'(exp_id_q.pop_front()); void'(exp_q_q.pop_front());
        void'(exp_m_q.pop_front());  void'(exp_dz_q.pop_front());
      end
      tick();
    end
    n_checks++; if (exp_id_q.size() != 0) begin n_fail++; $display("FAIL rand_lost: got %0d undelivered expected 0", exp_id_q.size()); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_multi();
    test_round_robin();
    test_stall();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
